// File: rtl/byte_packer.sv
// byte_packer -- gathers bytes popped from an upstream FIFO into wide words.
//
// Compile-time option: define PACKER_FLUSH_EN to add the flush input and the
// word_keep output, which allow a partially filled word to be emitted.
//
// Ports
//   clk, rst_n     single clock, asynchronous active-low reset
//   fifo_empty     upstream empty flag, valid in the same cycle
//   fifo_read_en   pop request (combinational)
//   fifo_data      pop data, valid the cycle after an accepted pop
//   word_out       packed word, lane 0 = first byte received
//   word_valid     word_out holds a word not yet taken downstream
//   word_ready     downstream accepts word_out when word_valid is high
//   flush          (PACKER_FLUSH_EN) emit the bytes gathered so far
//   word_keep      (PACKER_FLUSH_EN) per-byte valid mask for word_out
module byte_packer #(
    parameter int DATA_WIDTH     = 8,
    parameter int BYTES_PER_WORD = 4
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 fifo_empty,
    output logic                                 fifo_read_en,
    input  logic [DATA_WIDTH-1:0]                fifo_data,
    output logic [DATA_WIDTH*BYTES_PER_WORD-1:0] word_out,
    output logic                                 word_valid,
    input  logic                                 word_ready
`ifdef PACKER_FLUSH_EN
    ,
    input  logic                                 flush,
    output logic [BYTES_PER_WORD-1:0]            word_keep
`endif
);
    localparam int DW     = DATA_WIDTH;
    localparam int BPW    = BYTES_PER_WORD;
    localparam int CNT_W  = $clog2(BPW);
    localparam int PEND_W = CNT_W + 1;

    logic [CNT_W-1:0]       byte_cnt_q, byte_cnt_d;
    logic                   inflight_q, inflight_d;
    logic                   word_valid_q, word_valid_d;
    logic [BPW-1:0][DW-1:0] word_q, word_d;
    // The top lane never needs storage: its byte completes the word directly.
    logic [BPW-2:0][DW-1:0] asm_q, asm_d;

    logic [PEND_W-1:0]      pend_raw, pending;
    logic                   rd_ok, last_lane, flush_block;

`ifdef PACKER_FLUSH_EN
    logic                   flush_pend_q, flush_pend_d;
    logic [BPW-1:0]         keep_q, keep_d;
    logic [BPW-1:0][DW-1:0] partial;
    logic [BPW-1:0]         partial_keep;

    // Partial word: lanes below byte_cnt carry data, the rest read as zero.
    for (genvar g = 0; g < BPW; g++) begin : g_lane
        if (g < BPW-1) begin : g_asm
            assign partial[g] = (CNT_W'(g) < byte_cnt_q) ? asm_q[g] : '0;
        end else begin : g_top
            assign partial[g] = '0;
        end
        assign partial_keep[g] = (CNT_W'(g) < byte_cnt_q);
    end

    assign flush_block = flush_pend_q;
    assign word_keep   = keep_q;
`else
    assign flush_block = 1'b0;
`endif

    assign last_lane = (byte_cnt_q == CNT_W'(BPW-1));

    // Bytes already committed to the current word (captured + in flight).
    // A full count means the in-flight byte completes the word this edge, so
    // the next pop belongs to lane 0 of a fresh word: treat it as zero so the
    // stream keeps flowing across word boundaries.
    always_comb begin
        pend_raw     = {1'b0, byte_cnt_q} + PEND_W'(inflight_q);
        pending      = (pend_raw == PEND_W'(BPW)) ? '0 : pend_raw;
        // The pop that fills the top lane needs the output register free by
        // the time its data lands.
        rd_ok        = (pending < PEND_W'(BPW-1)) ||
                       ((pending == PEND_W'(BPW-1)) && (!word_valid_q || word_ready));
        fifo_read_en = rst_n && !fifo_empty && rd_ok && !flush_block;
    end

    always_comb begin
        byte_cnt_d   = byte_cnt_q;
        asm_d        = asm_q;
        word_d       = word_q;
        word_valid_d = word_valid_q;
        inflight_d   = fifo_read_en;
`ifdef PACKER_FLUSH_EN
        keep_d       = keep_q;
        flush_pend_d = flush_pend_q;
`endif
        if (word_valid_q && word_ready)
            word_valid_d = 1'b0;

        if (inflight_q) begin
            if (last_lane) begin
                word_d       = {fifo_data, asm_q};
                word_valid_d = 1'b1;
                byte_cnt_d   = '0;
`ifdef PACKER_FLUSH_EN
                keep_d       = '1;
`endif
            end else begin
                for (int i = 0; i < BPW-1; i++)
                    if (byte_cnt_q == CNT_W'(i))
                        asm_d[i] = fifo_data;
                byte_cnt_d = byte_cnt_q + CNT_W'(1);
            end
        end

`ifdef PACKER_FLUSH_EN
        // Wait for any in-flight byte to land so it is included in the flush.
        if (flush_pend_q) begin
            if (!inflight_q) begin
                if (byte_cnt_q == '0) begin
                    flush_pend_d = 1'b0;
                end else if (!word_valid_q || word_ready) begin
                    word_d       = partial;
                    keep_d       = partial_keep;
                    word_valid_d = 1'b1;
                    byte_cnt_d   = '0;
                    flush_pend_d = 1'b0;
                end
            end
        end else if (flush) begin
            flush_pend_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt_q   <= '0;
            inflight_q   <= 1'b0;
            word_valid_q <= 1'b0;
            word_q       <= '0;
            asm_q        <= '0;
`ifdef PACKER_FLUSH_EN
            keep_q       <= '0;
            flush_pend_q <= 1'b0;
`endif
        end else begin
            byte_cnt_q   <= byte_cnt_d;
            inflight_q   <= inflight_d;
            word_valid_q <= word_valid_d;
            word_q       <= word_d;
            asm_q        <= asm_d;
`ifdef PACKER_FLUSH_EN
            keep_q       <= keep_d;
            flush_pend_q <= flush_pend_d;
`endif
        end
    end

    assign word_out   = word_q;
    assign word_valid = word_valid_q;

endmodule

// File: tb/tb_byte_packer.sv
// tb_byte_packer -- self-checking bench for byte_packer (8-bit lanes, 4 per word).
// A queue-backed FIFO model feeds the DUT; accepted words are collected and
// compared with words formed directly from the bytes pushed.
module tb_byte_packer;
    localparam int DW  = 8;
    localparam int BPW = 4;
    localparam int WW  = DW * BPW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          fifo_empty;
    logic          fifo_read_en;
    logic [DW-1:0] fifo_data;
    logic [WW-1:0] word_out;
    logic          word_valid;
    logic          word_ready = 1'b0;
`ifdef PACKER_FLUSH_EN
    logic           flush = 1'b0;
    logic [BPW-1:0] word_keep;
    logic [BPW-1:0] got_keep[$];
`endif

    logic [DW-1:0] mem [0:4095];
    int            rd_ptr = 0;
    int            wr_ptr = 0;
    logic          force_empty = 1'b0;
    logic [WW-1:0] got_q[$];
    logic [DW-1:0] sent_q[$];
    int            n_tests = 0;
    int            n_fail  = 0;

    byte_packer #(.DATA_WIDTH(DW), .BYTES_PER_WORD(BPW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fifo_empty   (fifo_empty),
        .fifo_read_en (fifo_read_en),
        .fifo_data    (fifo_data),
        .word_out     (word_out),
        .word_valid   (word_valid),
        .word_ready   (word_ready)
`ifdef PACKER_FLUSH_EN
        ,
        .flush        (flush),
        .word_keep    (word_keep)
`endif
    );

    always #5 clk = ~clk;

    assign fifo_empty = force_empty || (rd_ptr == wr_ptr);

    // FIFO read port: data one cycle after an accepted pop, noise otherwise.
    always @(posedge clk) begin
        if (fifo_read_en && !fifo_empty) begin
            fifo_data <= mem[rd_ptr];
            rd_ptr    <= rd_ptr + 1;
        end else begin
            fifo_data <= DW'($urandom);
        end
        if (rst_n && word_valid && word_ready) begin
            got_q.push_back(word_out);
`ifdef PACKER_FLUSH_EN
            got_keep.push_back(word_keep);
`endif
        end
    end

    task automatic push(input logic [DW-1:0] b);
        mem[wr_ptr] = b;
        wr_ptr      = wr_ptr + 1;
        sent_q.push_back(b);
    endtask

    // Reference: next word is the next BPW bytes sent, first byte lowest.
    function automatic logic [WW-1:0] model_word();
        logic [WW-1:0] w;
        w = '0;
        for (int k = 0; k < BPW; k++)
            w = w | (WW'(sent_q.pop_front()) << (k * DW));
        return w;
    endfunction

    task automatic settle();
        word_ready  = 1'b1;
        force_empty = 1'b0;
        for (int i = 0; i < 100 && !(rd_ptr == wr_ptr && !word_valid); i++)
            @(negedge clk);
        repeat (3) @(negedge clk);
        got_q.delete();
        sent_q.delete();
`ifdef PACKER_FLUSH_EN
        got_keep.delete();
`endif
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        push(8'h5A);
        #1;
        n_tests++;
        if (fifo_read_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en got=%b exp=0", fifo_read_en); end
        n_tests++;
        if (word_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", word_valid); end
        n_tests++;
        if (word_out !== '0) begin n_fail++; $display("FAIL reset_word got=%h exp=0", word_out); end
        wr_ptr = rd_ptr;
        sent_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if (word_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_valid got=%b exp=0", word_valid); end
    endtask

    task automatic test_basic();
        int pops[$];
        int first_v;
        logic [WW-1:0] exp_w;
        settle();
        first_v = -1;
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        for (int i = 0; i < 20; i++) begin
            #1;
            if (fifo_read_en && !fifo_empty) pops.push_back(i);
            if (word_valid && first_v < 0) first_v = i;
            @(negedge clk);
        end
        exp_w = model_word();
        n_tests++;
        if (pops.size() != 4 || pops[3] - pops[0] != 3) begin
            n_fail++; $display("FAIL basic_pops got_count=%0d exp=4 consecutive", pops.size());
        end
        n_tests++;
        if (pops.size() == 4 && first_v != pops[3] + 2) begin
            n_fail++; $display("FAIL basic_latency got=%0d exp=%0d", first_v, pops[3] + 2);
        end
        n_tests++;
        if (got_q.size() != 1 || got_q[0] !== exp_w) begin
            n_fail++; $display("FAIL basic_word got_n=%0d got=%h exp=%h", got_q.size(), (got_q.size() > 0) ? got_q[0] : '0, exp_w);
        end
    endtask

    task automatic test_backpressure();
        int pops, viol;
        logic [WW-1:0] w0, w1, prev_w;
        logic prev_v, prev_r;
        settle();
        word_ready = 1'b0;
        pops = 0; viol = 0; prev_v = 0; prev_r = 0; prev_w = '0;
        for (int k = 1; k <= 8; k++) push(DW'(k));
        w0 = model_word();
        w1 = model_word();
        for (int i = 0; i < 10; i++) begin
            #1;
            if (fifo_read_en && !fifo_empty) pops++;
            if (prev_v && !prev_r && (!word_valid || word_out !== prev_w)) viol++;
            prev_v = word_valid; prev_r = word_ready; prev_w = word_out;
            @(negedge clk);
        end
        n_tests++;
        if (pops != 7) begin n_fail++; $display("FAIL bp_pops got=%0d exp=7", pops); end
        n_tests++;
        if (word_valid !== 1'b1 || word_out !== w0) begin
            n_fail++; $display("FAIL bp_hold got_v=%b got=%h exp=%h", word_valid, word_out, w0);
        end
        n_tests++;
        if (viol != 0) begin n_fail++; $display("FAIL bp_stable got=%0d exp=0", viol); end
        word_ready = 1'b1;
        for (int i = 0; i < 30 && got_q.size() < 2; i++) begin
            #1;
            if (fifo_read_en && !fifo_empty) pops++;
            @(negedge clk);
        end
        n_tests++;
        if (got_q.size() != 2 || got_q[0] !== w0 || got_q[1] !== w1) begin
            n_fail++; $display("FAIL bp_words got_n=%0d exp %h %h", got_q.size(), w0, w1);
        end
        n_tests++;
        if (pops != 8) begin n_fail++; $display("FAIL bp_total_pops got=%0d exp=8", pops); end
    endtask

    task automatic test_stream();
        int pops[$];
        int acc[$];
        logic [WW-1:0] exp_w;
        settle();
        for (int k = 0; k < 12; k++) push(DW'($urandom));
        for (int i = 0; i < 40; i++) begin
            #1;
            if (fifo_read_en && !fifo_empty) pops.push_back(i);
            if (word_valid && word_ready) acc.push_back(i);
            @(negedge clk);
        end
        n_tests++;
        if (pops.size() != 12 || pops[pops.size()-1] - pops[0] != 11) begin
            n_fail++; $display("FAIL stream_pops got_count=%0d exp=12 consecutive", pops.size());
        end
        n_tests++;
        if (acc.size() != 3 || acc[1] - acc[0] != 4 || acc[2] - acc[1] != 4) begin
            n_fail++; $display("FAIL stream_spacing got_count=%0d exp=3 words every 4 cycles", acc.size());
        end
        for (int w = 0; w < 3; w++) begin
            exp_w = model_word();
            n_tests++;
            if (got_q.size() <= w || got_q[w] !== exp_w) begin
                n_fail++; $display("FAIL stream_word%0d got=%h exp=%h", w, (got_q.size() > w) ? got_q[w] : '0, exp_w);
            end
        end
    endtask

    task automatic test_empty_toggle();
        int pops, viol;
        logic [WW-1:0] exp_w;
        settle();
        pops = 0; viol = 0;
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        exp_w = model_word();
        force_empty = 1'b1;
        for (int i = 0; i < 30; i++) begin
            #1;
            if (fifo_read_en && fifo_empty) viol++;
            if (fifo_read_en && !fifo_empty) pops++;
            @(negedge clk);
            force_empty = ~force_empty;
        end
        force_empty = 1'b0;
        n_tests++;
        if (viol != 0) begin n_fail++; $display("FAIL toggle_pop_while_empty got=%0d exp=0", viol); end
        n_tests++;
        if (pops != 4) begin n_fail++; $display("FAIL toggle_pops got=%0d exp=4", pops); end
        n_tests++;
        if (got_q.size() != 1 || got_q[0] !== exp_w) begin
            n_fail++; $display("FAIL toggle_word got_n=%0d exp=%h", got_q.size(), exp_w);
        end
    endtask

    task automatic test_reset_mid();
        logic [WW-1:0] exp_w;
        settle();
        // Two bytes captured and a third in flight when reset hits.
        push(8'h55); push(8'h66); push(8'h77);
        for (int i = 0; i < 3; i++) begin
            #1;
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (word_out !== '0 || word_valid !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_clear got_v=%b got=%h exp=0", word_valid, word_out);
        end
        sent_q.delete();
        push(8'hAA); push(8'hBB); push(8'hCC); push(8'hDD);
        exp_w = model_word();
        #1;
        n_tests++;
        if (fifo_read_en !== 1'b0) begin n_fail++; $display("FAIL rstmid_rd_en got=%b exp=0", fifo_read_en); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 30 && got_q.size() < 1; i++) @(negedge clk);
        n_tests++;
        if (got_q.size() != 1 || got_q[0] !== exp_w) begin
            n_fail++; $display("FAIL rstmid_word got_n=%0d got=%h exp=%h", got_q.size(), (got_q.size() > 0) ? got_q[0] : '0, exp_w);
        end
    endtask

`ifdef PACKER_FLUSH_EN
    task automatic test_flush();
        logic [WW-1:0] exp_w;
        settle();
        push(8'h11); push(8'h22);
        exp_w = WW'(sent_q[0]) | (WW'(sent_q[1]) << DW);
        sent_q.delete();
        repeat (6) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        push(8'h33);
        #1;
        n_tests++;
        if (fifo_read_en !== 1'b0) begin n_fail++; $display("FAIL flush_block_pop got=%b exp=0", fifo_read_en); end
        for (int i = 0; i < 10 && got_q.size() < 1; i++) @(negedge clk);
        n_tests++;
        if (got_q.size() < 1 || got_q[0] !== exp_w || got_keep[0] !== 4'b0011) begin
            n_fail++; $display("FAIL flush_partial got_n=%0d exp=%h keep 0011", got_q.size(), exp_w);
        end
        push(8'h44); push(8'h55); push(8'h66);
        exp_w = model_word();
        for (int i = 0; i < 20 && got_q.size() < 2; i++) @(negedge clk);
        n_tests++;
        if (got_q.size() < 2 || got_q[1] !== exp_w || got_keep[1] !== 4'b1111) begin
            n_fail++; $display("FAIL flush_full_after got_n=%0d exp=%h keep 1111", got_q.size(), exp_w);
        end
        // Flush with nothing gathered emits no word.
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        repeat (5) @(negedge clk);
        n_tests++;
        if (got_q.size() != 2) begin n_fail++; $display("FAIL flush_empty got_n=%0d exp=2", got_q.size()); end
    endtask
`endif

    task automatic test_random();
        int viol, cyc;
        logic [WW-1:0] exp_w, prev_w;
        logic prev_v, prev_r;
        settle();
        viol = 0; cyc = 0; prev_v = 0; prev_r = 0; prev_w = '0;
        for (int k = 0; k < 200; k++) push(DW'($urandom));
        while (got_q.size() < 50 && cyc < 4000) begin
            word_ready  = ($urandom_range(0, 3) != 0);
            force_empty = ($urandom_range(0, 3) == 0);
            #1;
            if (prev_v && !prev_r && (!word_valid || word_out !== prev_w)) viol++;
            prev_v = word_valid; prev_r = word_ready; prev_w = word_out;
            @(negedge clk);
            cyc++;
        end
        word_ready  = 1'b1;
        force_empty = 1'b0;
        n_tests++;
        if (got_q.size() != 50) begin n_fail++; $display("FAIL rand_count got=%0d exp=50", got_q.size()); end
        n_tests++;
        if (viol != 0) begin n_fail++; $display("FAIL rand_stable got=%0d exp=0", viol); end
        for (int w = 0; w < 50; w++) begin
            exp_w = model_word();
            n_tests++;
            if (got_q.size() <= w || got_q[w] !== exp_w) begin
                n_fail++; $display("FAIL rand_word%0d got=%h exp=%h", w, (got_q.size() > w) ? got_q[w] : '0, exp_w);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_stream();
        test_empty_toggle();
        test_reset_mid();
`ifdef PACKER_FLUSH_EN
        test_flush();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/byte_packer.md
BYTE_PACKER -- requirements
Module: byte_packer

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of one FIFO byte lane.
REQ-002 Parameter BYTES_PER_WORD, default 4, bytes per packed output word; legal range 2..16.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 fifo_empty  input  1  upstream FIFO empty flag; combinational, same-cycle valid.
REQ-006 fifo_read_en  output  1  pop request to upstream FIFO.
REQ-007 fifo_data  input  DATA_WIDTH  FIFO read data; valid exactly one cycle after a pop accepted (read_en=1 and empty=0).
REQ-008 word_out  output  DATA_WIDTH*BYTES_PER_WORD  packed word, registered.
REQ-009 word_valid  output  1  word_out holds an unconsumed word.
REQ-010 word_ready  input  1  downstream accepts word when word_valid=1 and word_ready=1.
REQ-011 flush  input  1  request to emit partial word (PACKER_FLUSH_EN only).
REQ-012 word_keep  output  BYTES_PER_WORD  per-byte valid mask for word_out (PACKER_FLUSH_EN only).

Function
REQ-013 Pop accepted = fifo_read_en & ~fifo_empty; block SHALL track one in-flight flag = pop accepted last cycle.
REQ-014 On each cycle with in-flight flag set, fifo_data SHALL be captured into assembly lane byte_cnt; byte_cnt increments.
REQ-015 Byte order: first captured byte at bits [DATA_WIDTH-1:0], byte k at [k*DATA_WIDTH +: DATA_WIDTH].
REQ-016 When the captured byte is lane BYTES_PER_WORD-1, at that same edge word_out SHALL load the complete word, word_valid SHALL set, byte_cnt SHALL return to 0.
REQ-017 fifo_read_en SHALL be 1 iff fifo_empty=0 and pending = byte_cnt + in-flight < BYTES_PER_WORD-1, or pending = BYTES_PER_WORD-1 and (word_valid=0 or word_ready=1); this guarantees no captured byte is ever lost.
REQ-018 Sustained throughput: one byte per cycle while FIFO non-empty and downstream ready; no bubble at word boundaries.
REQ-019 word_valid SHALL stay 1 and word_out SHALL stay stable until handshake; on handshake without new completion word_valid clears next edge.
REQ-020 Handshake and new-word completion in the same cycle: word_out SHALL load the new word, word_valid SHALL remain 1.
REQ-021 fifo_empty toggling mid-word SHALL only stall filling; partially assembled bytes are retained indefinitely.
REQ-022 fifo_read_en SHALL be combinational from registered state, fifo_empty and word_ready only.

Reset
REQ-023 rst_n low SHALL immediately clear byte_cnt, in-flight flag, word_valid, word_out (all zero), word_keep (zero), flush-pending.
REQ-024 Reset mid-word SHALL discard the partial word; a pop in flight at reset is dropped (its data ignored after release).
REQ-025 fifo_read_en SHALL be 0 while rst_n is low.

Configuration
REQ-026 Macro PACKER_FLUSH_EN: when defined, flush and word_keep exist; when undefined, neither port exists and behaviour is REQ-013..REQ-025 only.
REQ-027 With PACKER_FLUSH_EN: flush pulse sets flush-pending; while pending, fifo_read_en SHALL be 0.
REQ-028 Once pending and no in-flight byte: if byte_cnt>0 and (word_valid=0 or word_ready=1), word_out SHALL load the partial word with unused upper bytes zero, word_keep = (1<<byte_cnt)-1, byte_cnt=0, pending cleared; if byte_cnt=0, pending clears with no word emitted.
REQ-029 With PACKER_FLUSH_EN, full words SHALL carry word_keep = all ones.
REQ-030 flush asserted while pending SHALL have no additional effect.

Verification (DATA_WIDTH=8, BYTES_PER_WORD=4)
REQ-031 FIFO holds 11,22,33,44, word_ready=1 -> 4 consecutive pops, word_out=0x44332211 with word_valid=1 one cycle after last data beat.
REQ-032 8 bytes 01..08, word_ready=0 for 10 cycles -> first word 0x04030201 held stable, exactly 7 pops total until ready rises, then 0x08070605 follows with no byte lost.
REQ-033 Continuous stream of 12 bytes, ready=1 -> fifo_read_en high 12 consecutive cycles, 3 words on consecutive-4-cycle spacing.
REQ-034 FIFO empty alternating every cycle during 4-byte fill -> word 0x44332211 still correct, no pops while empty.
REQ-035 rst_n pulsed low after 2 of 4 bytes captured -> outputs zero immediately; next 4 bytes AA,BB,CC,DD produce 0xDDCCBBAA.
REQ-036 PACKER_FLUSH_EN: 2 bytes 11,22 then flush -> word_out=0x00002211, word_keep=0011, no further pops until pending clears.
